unified_mem_arbiter: RTL
========================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares the single-ported unified instruction/data memory between the IF stage (fetch port) and MEM stage (load/store port).
//  Grants one access at a time, sequences a fixed-latency memory transaction and returns a registered response.
//  Raises per-port stalls for the pipeline; IF fetches can be cancelled on branch flush.
//  Sits between the pipeline top level and the Memory block.
// PARAMETERS
//  ADDR_W      32  address width, both ports
//  DATA_W      32  data width
//  MEM_LAT     1   cycles from issue to mem_rdata valid; legal 1..7
//  STARVE_MAX  4   consecutive data grants while fetch waits before fetch is forced through; legal 1..15
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  if_req     in   1       fetch request; held until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_flush   in   1       cancel pending/in-flight fetch
//  if_gnt     out  1       fetch accepted this cycle
//  if_rvalid  out  1       one-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction, held until next fetch response
//  d_req      in   1       load/store request; held until d_gnt
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_func3    in   3       access size/sign (RV32 funct3)
//  d_gnt      out  1       data access accepted this cycle
//  d_rvalid   out  1       one-cycle completion pulse (loads and stores)
//  d_rdata    out  DATA_W  load data, held until next load response
//  stall_if   out  1       if_req pending or fetch in flight
//  stall_mem  out  1       d_req pending or data access in flight
//  mem_addr   out  ADDR_W  to Memory
//  mem_wdata  out  DATA_W  to Memory
//  mem_func3  out  3       to Memory
//  mem_read   out  1       to Memory
//  mem_write  out  1       to Memory
//  mem_rdata  in   DATA_W  from Memory
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; all outputs 0; starve counter 0; discard flag 0. An in-flight access is aborted and a store may be lost.
//  States: IDLE, BUSY. Held registers: owner (I/D), addr, wdata, func3, we, lat counter.
//  IDLE, cycle T: if any request is eligible, pulse the winner's gnt (combinational), latch its fields, go BUSY with lat counter = MEM_LAT.
//  Arbitration: d_req wins over if_req, except when starve counter == STARVE_MAX and if_req=1; then fetch wins.
//  Starve counter: +1 per data grant while if_req=1 (saturates); cleared on fetch grant or when if_req=0.
//  if_flush=1 in IDLE: fetch not eligible that cycle, so data may still be granted.
//  BUSY, cycles T+1..T+MEM_LAT: mem_addr/mem_func3/mem_wdata driven from held regs.
//    mem_read = !we for the whole window; mem_write = we in the first BUSY cycle only.
//    Outside BUSY all mem_* outputs = 0.
//  Last BUSY cycle: capture mem_rdata into owner's rdata (loads/fetches only); next cycle (T+MEM_LAT+1) owner rvalid pulses for 1 cycle and state = IDLE.
//    A new grant is allowed in that same cycle. Throughput: one access per MEM_LAT+1 cycles.
//  Flush: if_flush=1 at any BUSY cycle of a fetch sets the discard flag.
//    The access completes on memory, but if_rvalid is suppressed and if_rdata is not updated; the flag clears on return to IDLE.
//  Stores: d_rvalid pulses; d_rdata unchanged.
//  stall_if  = (if_req & ~if_gnt) | (BUSY & owner==I & ~discard).
//  stall_mem = (d_req & ~d_gnt) | (BUSY & owner==D).
//  Requests deasserted before grant are dropped silently. Requests are not checked during BUSY.
// STRUCTURE
//  Shared header pipeline_defs.vh: state encodings, owner encoding, funct3 size constants (LB/LH/LW/LBU/LHU/SB/SH/SW).
//  Reuse NbitRegister for the held request fields and both rdata holders. No new sub-module; FSM and counters stay inline.
// TESTING
//  1. rst=0 mid-BUSY store -> all outputs 0 immediately; after release, IDLE with no rvalid pulse.
//  2. MEM_LAT=1; if_req, addr 0x10; mem returns 0x00500093 -> if_gnt at T, mem_read T+1, if_rvalid/if_rdata=0x00500093 at T+2.
//  3. if_req and d_req (load 0x40) together -> d_gnt first, d_rvalid at T+2, if_gnt at T+2, if_rvalid at T+4.
//  4. d_req held 6 accesses with if_req high, STARVE_MAX=4 -> fetch granted after exactly 4 data grants.
//  5. Fetch granted at T, if_flush at T+1 -> no if_rvalid, if_rdata unchanged, stall_if=0 from T+1.
//  6. Store SB 0xAB to 0x23 -> mem_write high exactly 1 cycle, d_rvalid at T+2, d_rdata unchanged; then load LBU 0x23 returns 0x000000AB.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg
//   Shared encodings for the unified memory arbiter: FSM states, access
//   owner, RV32 funct3 size/sign codes and a saturating-increment helper.
package unified_mem_arbiter_pkg;

   // FSM states
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Owner of the access currently held in the arbiter
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   // RV32 funct3 size/sign codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Increment that sticks at max
   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] max);
      return (v >= max) ? max : v + 4'd1;
   endfunction

endpackage

// File: rtl/unified_mem_arbiter_nreg.sv
// unified_mem_arbiter_nreg
//   N-bit register with load enable, asynchronous active-low clear.
//   Used for the held request fields and both read-data holders.
// Ports
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-low reset (q -> 0)
//   en   in   load d into q on this edge
//   d    in   W  next value
//   q    out  W  registered value
module unified_mem_arbiter_nreg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported unified memory between the fetch port (IF) and
//   the load/store port (MEM). One access at a time: grant in IDLE, hold the
//   request for MEM_LAT cycles in BUSY, capture read data in the last BUSY
//   cycle and pulse the owner's rvalid on the following cycle.
// Ports
//   clk, rst                         clock / async active-low reset
//   if_req/if_addr/if_flush          fetch request, address, cancel
//   if_gnt/if_rvalid/if_rdata        fetch grant, response pulse, held data
//   d_req/d_we/d_addr/d_wdata/d_func3  load/store request
//   d_gnt/d_rvalid/d_rdata           data grant, completion pulse, held data
//   stall_if/stall_mem               per-port pipeline stalls
//   mem_addr/mem_wdata/mem_func3/mem_read/mem_write  to Memory
//   mem_rdata                        from Memory
module unified_mem_arbiter
   import unified_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [2:0]        d_func3,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              stall_if,
   output logic              stall_mem,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_func3,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [2:0] LAT  = 3'(MEM_LAT);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);
   // held fields: {owner, we, func3, addr, wdata}
   localparam int HW = 1 + 1 + 3 + ADDR_W + DATA_W;

   logic [0:0]        state_q;
   logic [2:0]        lat_q;
   logic [3:0]        starve_q;
   logic              discard_q;
   logic              if_rvalid_q, d_rvalid_q;

   logic              idle, busy, first_busy, last_busy;
   logic              fetch_first, gnt_i, gnt_d, any_gnt;
   logic              flush_now, discard_eff;
   logic              own_i, own_d, cap_i, cap_d;

   logic [HW-1:0]     hold_d, hold_q;
   logic              h_owner, h_we;
   logic [2:0]        h_func3;
   logic [ADDR_W-1:0] h_addr;
   logic [DATA_W-1:0] h_wdata;

   assign idle = (state_q == ST_IDLE);
   assign busy = ~idle;

   // ---------------- arbitration (combinational grant) ----------------
   // Data wins unless fetch has been starved STARVE_MAX grants. A flushing
   // fetch is not eligible, so data can still go in that cycle.
   assign fetch_first = if_req & ~if_flush & (~d_req | (starve_q == SMAX));
   assign gnt_i   = rst & idle & fetch_first;
   assign gnt_d   = rst & idle & d_req & ~fetch_first;
   assign any_gnt = gnt_i | gnt_d;

   // Fetches are issued as word reads with no write data.
   assign hold_d = gnt_i ? {OWN_I, 1'b0, F3_LW, if_addr, {DATA_W{1'b0}}}
                         : {OWN_D, d_we, d_func3, d_addr, d_wdata};

   unified_mem_arbiter_nreg #(.W(HW)) u_hold (
      .clk (clk),
      .rst (rst),
      .en  (any_gnt),
      .d   (hold_d),
      .q   (hold_q)
   );

   assign {h_owner, h_we, h_func3, h_addr, h_wdata} = hold_q;

   assign own_i      = (h_owner == OWN_I);
   assign own_d      = (h_owner == OWN_D);
   assign first_busy = busy & (lat_q == LAT);
   assign last_busy  = busy & (lat_q == 3'd1);

   // A flush seen in the current BUSY cycle takes effect immediately so the
   // stall drops and a flush in the last cycle still suppresses the response.
   assign flush_now   = busy & own_i & if_flush;
   assign discard_eff = discard_q | flush_now;

   assign cap_i = last_busy & own_i & ~discard_eff;
   assign cap_d = last_busy & own_d & ~h_we;

   // ---------------- FSM and latency counter ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         lat_q       <= 3'd0;
         discard_q   <= 1'b0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
      end else begin
         if_rvalid_q <= cap_i;
         d_rvalid_q  <= last_busy & own_d;
         if (idle) begin
            discard_q <= 1'b0;
            if (any_gnt) begin
               state_q <= ST_BUSY;
               lat_q   <= LAT;
            end
         end else begin
            lat_q <= lat_q - 3'd1;
            if (last_busy) begin
               state_q   <= ST_IDLE;
               discard_q <= 1'b0;
            end else begin
               discard_q <= discard_eff;
            end
         end
      end
   end

   // ---------------- starvation counter ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        starve_q <= 4'd0;
      else if (!if_req) starve_q <= 4'd0;
      else if (gnt_i)   starve_q <= 4'd0;
      else if (gnt_d)   starve_q <= sat_inc(starve_q, SMAX);
   end

   // ---------------- read-data holders ----------------
   unified_mem_arbiter_nreg #(.W(DATA_W)) u_if_rdata (
      .clk (clk),
      .rst (rst),
      .en  (cap_i),
      .d   (mem_rdata),
      .q   (if_rdata)
   );

   unified_mem_arbiter_nreg #(.W(DATA_W)) u_d_rdata (
      .clk (clk),
      .rst (rst),
      .en  (cap_d),
      .d   (mem_rdata),
      .q   (d_rdata)
   );

   // ---------------- outputs ----------------
   assign if_gnt    = gnt_i;
   assign d_gnt     = gnt_d;
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;

   // Gated by rst so every output is 0 while reset is asserted.
   assign stall_if  = rst & ((if_req & ~gnt_i) | (busy & own_i & ~discard_eff));
   assign stall_mem = rst & ((d_req  & ~gnt_d) | (busy & own_d));

   assign mem_addr  = busy ? h_addr  : '0;
   assign mem_wdata = busy ? h_wdata : '0;
   assign mem_func3 = busy ? h_func3 : 3'd0;
   assign mem_read  = busy & ~h_we;
   // Store strobe only on the issue cycle so the memory writes once.
   assign mem_write = first_busy & h_we;

endmodule
